// File: rtl/ppg_afe_model.sv
// Closed-loop PPG front-end model: triangle red/IR pulse, DC subtraction, PGA gain, 8-bit ADC clamp.
// Latency 3 edges from input sample to ADC, one sample per cycle; adc_valid high once the pipeline fills.
// No backpressure (free running); define PPG_AFE_NOISE_EN to add LFSR dither ahead of the gain stage.
module ppg_afe_model #(
   parameter int PERIOD     = 1000,
   parameter int RED_DC     = 600,
   parameter int IR_DC      = 500,
   parameter int AC_SHIFT   = 3,
   parameter int DC_STEP    = 4,
   parameter int DARK_LEVEL = 0,
   parameter int SETTLE     = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       LED_RED,
   input  logic       LED_IR,
   input  logic [6:0] DC_Comp,
   input  logic [3:0] PGA_Gain,
   output logic [7:0] ADC,
   output logic       adc_valid
);

   localparam logic [9:0]  PER_LAST   = 10'(PERIOD - 1);
   localparam logic [9:0]  PER_HALF   = 10'(PERIOD / 2);
   localparam logic [10:0] PER_FULL   = 11'(PERIOD);
   localparam logic [11:0] RED_BASE   = 12'(RED_DC);
   localparam logic [11:0] IR_BASE    = 12'(IR_DC);
   localparam logic [11:0] DARK_RAW   = 12'(DARK_LEVEL);
   localparam logic [11:0] DC_MULT    = 12'(DC_STEP);
   localparam logic [11:0] RAW_MAX    = 12'd1023;
   localparam logic [7:0]  BLANK_LOAD = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;
   localparam bit          BLANK_EN   = (SETTLE > 0);

   logic [9:0]         phase;
   logic [9:0]         tri_wave;
   logic [9:0]         ac_lvl;
   logic [11:0]        red_lvl;
   logic [11:0]        ir_lvl;
   logic [11:0]        both_lvl;
   logic [11:0]        raw;
   logic [11:0]        dc_sub;
   logic signed [11:0] noise;
   logic signed [11:0] diff_c;

   logic [1:0]         led_now;
   logic [1:0]         led_prev;
   logic               led_chg;
   logic [7:0]         blank_cnt;
   logic [7:0]         blank_cnt_nxt;
   logic               blank_c;

   logic signed [11:0] s1_diff;
   logic [3:0]         s1_gain;
   logic               s1_blank;
   logic signed [16:0] s2_amp;
   logic               s2_blank;

   logic [4:0]         gain_p1;
   logic signed [16:0] diff_ext;
   logic signed [16:0] gain_ext;
   logic signed [16:0] mult;
   logic signed [16:0] amp_c;
   logic signed [16:0] adc_sum;
   logic [7:0]         adc_c;

   logic [1:0]         vld_sr;

   // Pulse synthesis: symmetric triangle over one PERIOD, scaled down onto each baseline.
   always_comb begin
      tri_wave = phase;
      if (phase >= PER_HALF) begin
         tri_wave = 10'(PER_FULL - {1'b0, phase});
      end
      ac_lvl   = tri_wave >> AC_SHIFT;
      red_lvl  = RED_BASE + {2'b00, ac_lvl};
      ir_lvl   = IR_BASE + {2'b00, ac_lvl};
      both_lvl = red_lvl + ir_lvl;
   end

   assign led_now = {LED_RED, LED_IR};

   always_comb begin
      raw = DARK_RAW;
      case (led_now)
         2'b10:   raw = red_lvl;
         2'b01:   raw = ir_lvl;
         2'b11:   raw = (both_lvl > RAW_MAX) ? RAW_MAX : both_lvl;
         default: raw = DARK_RAW;
      endcase
   end

`ifdef PPG_AFE_NOISE_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
      end
   end

   assign noise = {{9{lfsr[2]}}, lfsr[2:0]};
`else
   assign noise = '0;
`endif

   assign dc_sub = 12'(DC_Comp) * DC_MULT;
   assign diff_c = $signed(raw) - $signed(dc_sub) + noise;

   // A new LED change always restarts the settle window, even mid-window.
   assign led_chg = (led_now != led_prev);

   always_comb begin
      blank_cnt_nxt = blank_cnt;
      blank_c       = 1'b0;
      if (led_chg) begin
         blank_cnt_nxt = BLANK_LOAD;
         blank_c       = BLANK_EN;
      end else if (blank_cnt != 8'd0) begin
         blank_cnt_nxt = blank_cnt - 8'd1;
         blank_c       = 1'b1;
      end
   end

   always_comb begin
      gain_p1  = {1'b0, s1_gain} + 5'd1;
      diff_ext = {{5{s1_diff[11]}}, s1_diff};
      gain_ext = $signed({12'd0, gain_p1});
      mult     = diff_ext * gain_ext;
      amp_c    = mult >>> 1;
   end

   always_comb begin
      adc_sum = s2_amp + 17'sd128;
      adc_c   = adc_sum[7:0];
      if (adc_sum < 17'sd0) begin
         adc_c = 8'd0;
      end else if (adc_sum > 17'sd255) begin
         adc_c = 8'd255;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= '0;
         led_prev  <= 2'b00;
         blank_cnt <= '0;
      end else begin
         phase     <= (phase == PER_LAST) ? 10'd0 : phase + 10'd1;
         led_prev  <= led_now;
         blank_cnt <= blank_cnt_nxt;
      end
   end

   // Gain travels with its sample so every input is taken from the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_diff  <= '0;
         s1_gain  <= '0;
         s1_blank <= 1'b0;
         s2_amp   <= '0;
         s2_blank <= 1'b0;
      end else begin
         s1_diff  <= diff_c;
         s1_gain  <= PGA_Gain;
         s1_blank <= blank_c;
         s2_amp   <= amp_c;
         s2_blank <= s1_blank;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ADC       <= 8'd128;
         vld_sr    <= 2'b00;
         adc_valid <= 1'b0;
      end else begin
         if (!s2_blank) begin
            ADC <= adc_c;
         end
         vld_sr    <= {vld_sr[0], 1'b1};
         adc_valid <= vld_sr[1];
      end
   end

endmodule

// File: tb/tb_ppg_afe_model.sv
// Bench for ppg_afe_model: directed steps plus random stimulus against an arithmetic reference model.
module tb_ppg_afe_model;

   localparam int PERIOD = 1000;
   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       LED_RED;
   logic       LED_IR;
   logic [6:0] DC_Comp;
   logic [3:0] PGA_Gain;
   logic [7:0] ADC;
   logic       adc_valid;

   ppg_afe_model dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .LED_RED   (LED_RED),
      .LED_IR    (LED_IR),
      .DC_Comp   (DC_Comp),
      .PGA_Gain  (PGA_Gain),
      .ADC       (ADC),
      .adc_valid (adc_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int val;
      bit blank;
      int ph;
   } ent_t;

   ent_t       pipe[$];
   int         n_pass  = 0;
   int         n_fail  = 0;
   int         n_total = 0;
   int         phase;
   int         edges;
   int         blank_left;
   logic [1:0] prev_led;
   int         model_adc;
   int         out_ph;
   bit         out_blank;

   // Expected ADC code for one sample, straight from the transfer function.
   function automatic int afe(input int ph, input bit r, input bit i, input int dc, input int g);
      int tw, lvl, red, ir, raw, diff, amp, v;
      tw  = (ph < PERIOD / 2) ? ph : PERIOD - ph;
      lvl = tw / 8;
      red = 600 + lvl;
      ir  = 500 + lvl;
      if (r && i)  raw = (red + ir > 1023) ? 1023 : red + ir;
      else if (r)  raw = red;
      else if (i)  raw = ir;
      else         raw = 0;
      diff = raw - dc * 4;
      amp  = diff * (g + 1);
      amp  = amp >>> 1;
      v    = amp + 128;
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ent_t e;
      phase      = 0;
      edges      = 0;
      blank_left = 0;
      prev_led   = 2'b00;
      model_adc  = 128;
      out_ph     = -1;
      out_blank  = 1'b0;
      pipe.delete();
      e.val = 128; e.blank = 1'b0; e.ph = -1;
      pipe.push_back(e);
      pipe.push_back(e);
   endtask

   task automatic apply_reset();
      LED_RED  = 1'b0;
      LED_IR   = 1'b0;
      DC_Comp  = '0;
      PGA_Gain = '0;
      rst_n    = 1'b0;
      #1;
      chk("rst_adc_async", 32'(ADC), 32'd128);
      chk("rst_valid_async", 32'(adc_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_adc_hold", 32'(ADC), 32'd128);
      chk("rst_valid_hold", 32'(adc_valid), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one sample, clock it, advance the model and check both outputs.
   task automatic step(input bit r, input bit i, input int dc, input int g);
      ent_t e;
      LED_RED  = r;
      LED_IR   = i;
      DC_Comp  = 7'(dc);
      PGA_Gain = 4'(g);
      @(posedge clk);
      if ({r, i} != prev_led) blank_left = SETTLE;
      e.val   = afe(phase, r, i, dc, g);
      e.blank = (blank_left > 0);
      e.ph    = phase;
      if (blank_left > 0) blank_left--;
      prev_led = {r, i};
      pipe.push_back(e);
      phase = (phase + 1) % PERIOD;
      edges++;
      e         = pipe.pop_front();
      out_ph    = e.ph;
      out_blank = e.blank;
      if (!e.blank) model_adc = e.val;
      #1;
      chk("adc", 32'(ADC), 32'(model_adc));
      chk("valid", 32'(adc_valid), (edges >= 3) ? 32'd1 : 32'd0);
   endtask

   initial begin
      bit r_cur, i_cur;
      int held;
      r_cur = 1'b0;
      i_cur = 1'b0;
      rst_n = 1'b1;
      LED_RED = 1'b0; LED_IR = 1'b0; DC_Comp = '0; PGA_Gain = '0;
      #3;
      apply_reset();

      step(0, 0, 0, 0);
      chk("valid_e1", 32'(adc_valid), 32'd0);
      chk("adc_e1", 32'(ADC), 32'd128);
      step(0, 0, 0, 0);
      chk("valid_e2", 32'(adc_valid), 32'd0);
      step(0, 0, 0, 0);
      chk("valid_e3", 32'(adc_valid), 32'd1);
      chk("adc_e3", 32'(ADC), 32'd128);

      while (phase != 990) begin
         if ($urandom_range(0, 15) == 0) {r_cur, i_cur} = 2'($urandom_range(0, 3));
         step(r_cur, i_cur, int'($urandom_range(0, 127)), int'($urandom_range(0, 15)));
      end

      // Nominal red over a full wrap and into the next period.
      for (int k = 0; k < 1015; k++) begin
         step(1, 0, 125, 0);
         if (!out_blank && out_ph == 0)   chk("red_ph0", 32'(ADC), 32'd178);
         if (!out_blank && out_ph == 250) chk("red_ph250", 32'(ADC), 32'd193);
         if (!out_blank && out_ph == 500) chk("red_ph500", 32'(ADC), 32'd209);
         if (!out_blank && out_ph == 999) chk("red_ph999", 32'(ADC), 32'd178);
      end

      #3;
      apply_reset();

      // IR with max gain saturates high; first two samples blanked by the LED turn-on.
      step(0, 1, 100, 15);
      step(0, 1, 100, 15);
      step(0, 1, 100, 15);
      chk("irsat_blank0", 32'(ADC), 32'd128);
      step(0, 1, 100, 15);
      chk("irsat_blank1", 32'(ADC), 32'd128);
      step(0, 1, 100, 15);
      chk("irsat", 32'(ADC), 32'd255);
      step(0, 1, 100, 15);
      chk("irsat_next", 32'(ADC), 32'd255);

      // Dark with heavy compensation saturates low.
      step(0, 0, 126, 15);
      step(0, 0, 126, 15);
      step(0, 0, 126, 15);
      step(0, 0, 126, 15);
      chk("lowsat_hold", 32'(ADC), 32'd255);
      step(0, 0, 126, 15);
      chk("lowsat", 32'(ADC), 32'd0);

      // Red to IR switch: two held outputs, then IR.
      repeat (6) step(1, 0, 125, 0);
      step(0, 1, 100, 0);
      step(0, 1, 100, 0);
      held = model_adc;
      step(0, 1, 100, 0);
      chk("switch_hold0", 32'(ADC), 32'(held));
      step(0, 1, 100, 0);
      chk("switch_hold1", 32'(ADC), 32'(held));
      step(0, 1, 100, 0);
      chk("switch_ir", 32'(ADC), 32'(afe(out_ph, 0, 1, 100, 0)));

      // Toggle away and straight back: window extends to three samples.
      step(1, 0, 125, 0);
      step(0, 1, 100, 0);
      held = model_adc;
      step(0, 1, 100, 0);
      chk("retoggle_hold0", 32'(ADC), 32'(held));
      step(0, 1, 100, 0);
      chk("retoggle_hold1", 32'(ADC), 32'(held));
      step(0, 1, 100, 0);
      chk("retoggle_hold2", 32'(ADC), 32'(held));
      step(0, 1, 100, 0);
      chk("retoggle_resume", 32'(ADC), 32'(afe(out_ph, 0, 1, 100, 0)));

      // Random LED churn to exercise overlapping blank windows.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 2) == 0) {r_cur, i_cur} = 2'($urandom_range(0, 3));
         step(r_cur, i_cur, int'($urandom_range(0, 127)), int'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ppg_afe_model.md
# ppg_afe_model

Synthesizable behavioural model of the pulse-oximeter analog front end: the far end of the LED / DC-compensation / PGA / ADC interface driven by the controller. It takes the LED enables, the 7-bit DC compensation code and the 4-bit PGA gain, synthesizes a triangular red/IR photoplethysmogram, and applies offset subtraction, gain and 8-bit saturation. It returns the ADC sample through a fixed 3-stage pipeline. It serves as the closed-loop stimulus for controller simulation and FPGA bring-up.

## Interface
- PERIOD, 1000: samples per synthetic pulse cycle; must be even and at least 4.
- RED_DC, 600: red baseline, unsigned 10-bit.
- IR_DC, 500: IR baseline, unsigned 10-bit.
- AC_SHIFT, 3: right shift applied to the triangle before it is added to the baseline.
- DC_STEP, 4: raw counts removed per DC_Comp LSB.
- DARK_LEVEL, 0: raw level when no LED is lit.
- SETTLE, 2: samples blanked after any LED change; 0 disables blanking.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- LED_RED  in  1  red LED enable.
- LED_IR  in  1  IR LED enable.
- DC_Comp  in  7  DC offset code.
- PGA_Gain  in  4  PGA gain code.
- ADC  out  8  converted sample; mid-scale is 128.
- adc_valid  out  1  high once the pipeline is filled after reset.

## Operation
- **Phase counter.**
  - phase is 10 bits and runs 0..PERIOD-1, then wraps to 0, every cycle, regardless of the LED state.
  - tri = phase when phase < PERIOD/2, otherwise PERIOD-phase.
- **Channel levels.**
  - red = RED_DC + (tri >> AC_SHIFT).
  - ir = IR_DC + (tri >> AC_SHIFT).
- **Raw select.**
  - LED_RED only: red.
  - LED_IR only: ir.
  - Both LEDs: red+ir, saturated to 1023.
  - Neither LED: DARK_LEVEL.
- **Stage 1.** diff = raw − DC_Comp·DC_STEP, as a signed 12-bit value. A blank tag is also computed (see below).
- **Stage 2.** amp = (diff · (PGA_Gain+1)) >>> 1, using a signed 17-bit intermediate and arithmetic shift.
- **Stage 3.**
  - ADC = clamp(amp+128, 0, 255).
  - If the stage-3 blank tag is set, ADC holds its previous value.
- **Blanking.**
  - A change of {LED_RED, LED_IR} against its registered previous value sets the tag and loads blank_cnt = SETTLE−1.
  - While blank_cnt is nonzero, the tag stays set and blank_cnt decrements.
  - Net effect: exactly SETTLE consecutive samples are blanked.
  - A new change during blanking restarts the count.
  - With SETTLE=0 the tag is never set.
- **Reset values.**
  - ADC=128, adc_valid=0.
  - phase=0, blank_cnt=0.
  - Previous-LED register = 00.
  - Pipeline registers cleared, blank tags clear.
  - LFSR=16'hACE1.
  - Asserting reset mid-operation returns every register to these values immediately.

## Timing
- Inputs and phase sampled at edge t appear on ADC after edge t+2: latency 3 edges, throughput one sample per cycle.
- adc_valid rises after the 3rd rising edge following rst_n deassertion and stays high until the next reset.
- ADC is not gated by adc_valid; before adc_valid is high it reads 128.
- DC_Comp and PGA_Gain may change on any cycle; there is no handshake.

## Configuration
- **PPG_AFE_NOISE_EN defined:**
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - The signed value lfsr[2:0] (range −4..+3) is added to diff in stage 1, before gain.
- **PPG_AFE_NOISE_EN undefined:** no LFSR is instantiated and the output is fully deterministic. All test-plan values assume this mode.

## Test plan
- **Reset.** Release rst_n with the LEDs off.
  - ADC=128 and adc_valid=0 through 2 edges.
  - adc_valid=1 after the 3rd edge.
  - Reassert rst_n mid-run: ADC=128 and adc_valid=0 immediately.
- **Nominal red sample.** LED_RED=1, DC_Comp=125, PGA_Gain=0, sampled at phase 0.
  - diff=100, amp=50, ADC=178 three edges later.
  - Same conditions at phase 500: diff=162, ADC=209.
- **Gain and high saturation.** LED_IR=1, DC_Comp=100, PGA_Gain=15, phase 0.
  - diff=100, amp=800, ADC=255.
- **Low saturation.** Both LEDs off, DC_Comp=126, PGA_Gain=15.
  - diff=−504, ADC=0.
- **Blanking.** Switch from red to IR with SETTLE=2.
  - The 2 samples taken at and after the switch leave ADC unchanged.
  - The 3rd sample shows the IR value.
  - A second toggle inside the window extends blanking by 2 from that toggle.
- **Phase wrap.** Run 1000 cycles with LED_RED=1, DC_Comp=125, PGA_Gain=0.
  - ADC peaks at 209 for the phase-500 sample.
  - phase 999 gives tri=1 (ADC=178), then wraps to phase 0 (ADC=178).
  - The 1000-cycle ramp repeats identically.
